// File: rtl/axi_user_tester_if.sv
// User-side write/read port bundle between the traffic tester and the AXI channel top.
interface axi_user_tester_if #(
  parameter int P_USER_DATA_WIDTH = 16,
  parameter int P_AXI_ADDR_WIDTH  = 32
);
  logic [P_USER_DATA_WIDTH-1:0] o_user_data;
  logic                         o_user_valid;
  logic [P_AXI_ADDR_WIDTH-1:0]  o_wuser_baddr;
  logic [P_AXI_ADDR_WIDTH-1:0]  o_wuser_faddr;
  logic                         o_user_req;
  logic                         i_user_busy;
  logic [P_AXI_ADDR_WIDTH-1:0]  o_ruser_baddr;
  logic [P_AXI_ADDR_WIDTH-1:0]  o_ruser_faddr;
  logic [P_USER_DATA_WIDTH-1:0] i_rd_data;
  logic                         i_rd_valid;
  logic                         i_rd_last;

  modport master (
    output o_user_data, o_user_valid, o_wuser_baddr, o_wuser_faddr,
    output o_user_req, o_ruser_baddr, o_ruser_faddr,
    input  i_user_busy, i_rd_data, i_rd_valid, i_rd_last
  );

  modport slave (
    input  o_user_data, o_user_valid, o_wuser_baddr, o_wuser_faddr,
    input  o_user_req, o_ruser_baddr, o_ruser_faddr,
    output i_user_busy, i_rd_data, i_rd_valid, i_rd_last
  );
endinterface

// File: rtl/axi_user_tester.sv
// DDR path bring-up tester: writes counter-pattern frames, reads them back and
// counts verified frames and mismatched words.
module axi_user_tester #(
  parameter int     P_WR_LENGTH       = 4096,
  parameter int     P_USER_DATA_WIDTH = 16,
  parameter int     P_AXI_ADDR_WIDTH  = 32,
  parameter longint P_BASE_ADDR       = 0,
  parameter int     P_FRAME_NUM       = 4,
  parameter int     P_WR_WAIT         = 256
) (
  input  logic                     i_user_clk,
  input  logic                     i_rst,
  input  logic                     i_ddr_init,
  axi_user_tester_if.master        bus,
  output logic [15:0]              o_frame_cnt,
  output logic [15:0]              o_err_cnt,
  output logic                     o_err,
  output logic                     o_done
);

  localparam int P_WORDS    = P_WR_LENGTH / (P_USER_DATA_WIDTH / 8);
  localparam int IDX_W      = $clog2(P_WORDS + 1) + 1;
  localparam int WAIT_W     = $clog2(P_WR_WAIT + 1) + 1;
  localparam int FRAMES_EFF = (P_FRAME_NUM == 0) ? 1 : P_FRAME_NUM;

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(P_WORDS - 1);
  localparam logic [IDX_W-1:0]  WORDS_IDX = IDX_W'(P_WORDS);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((P_WR_WAIT > 0) ? P_WR_WAIT - 1 : 0);

  localparam longint FADDR_L = P_BASE_ADDR + longint'(P_WR_LENGTH) * longint'(FRAMES_EFF) - 1;
  localparam logic [P_AXI_ADDR_WIDTH-1:0] BADDR = P_AXI_ADDR_WIDTH'(P_BASE_ADDR);
  localparam logic [P_AXI_ADDR_WIDTH-1:0] FADDR = P_AXI_ADDR_WIDTH'(FADDR_L);

  typedef enum logic [2:0] {IDLE, WR, WAIT, REQ, RD, NEXT, DONE} state_t;

  state_t state;
  state_t state_nxt;

  logic                         init_p0;
  logic                         init_p1;
  logic [P_USER_DATA_WIDTH-1:0] wr_cnt;
  logic [P_USER_DATA_WIDTH-1:0] exp_cnt;
  logic [P_USER_DATA_WIDTH-1:0] user_data;
  logic                         user_valid;
  logic                         user_req;
  logic [IDX_W-1:0]             wr_idx;
  logic [IDX_W-1:0]             rd_idx;
  logic [WAIT_W-1:0]            wait_cnt;
  logic [1:0]                   err_inc;
  logic                         last_frame;

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {15'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  assign bus.o_wuser_baddr = BADDR;
  assign bus.o_wuser_faddr = FADDR;
  assign bus.o_ruser_baddr = BADDR;
  assign bus.o_ruser_faddr = FADDR;
  assign bus.o_user_data   = user_data;
  assign bus.o_user_valid  = user_valid;
  assign bus.o_user_req    = user_req;

  assign last_frame = (P_FRAME_NUM != 0) &&
                      ((32'(o_frame_cnt) + 32'd1) == 32'(P_FRAME_NUM));

  // Stage p0/p1: calibration-done synchronizer from the AXI domain
  always_ff @(posedge i_user_clk or posedge i_rst) begin
    if (i_rst) begin
      init_p0 <= 1'b0;
      init_p1 <= 1'b0;
    end else begin
      init_p0 <= i_ddr_init;
      init_p1 <= init_p0;
    end
  end

  always_ff @(posedge i_user_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    user_req  = 1'b0;
    case (state)
      IDLE: if (init_p1) state_nxt = WR;
      WR:   if (wr_idx == LAST_IDX) state_nxt = WAIT;
      WAIT: if (wait_cnt == WAIT_LAST) state_nxt = REQ;
      REQ: begin
        if (!bus.i_user_busy) begin
          user_req  = 1'b1;
          state_nxt = RD;
        end
      end
      RD:   if (bus.i_rd_valid && bus.i_rd_last) state_nxt = NEXT;
      NEXT: state_nxt = last_frame ? DONE : WR;
      DONE: state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Data compare, length check and stray-valid detection feed the error counter
  always_comb begin
    err_inc = 2'd0;
    if (bus.i_rd_valid) begin
      if (state == RD) begin
        if (bus.i_rd_data != exp_cnt) err_inc = err_inc + 2'd1;
        if (bus.i_rd_last ? (rd_idx != LAST_IDX) : (rd_idx >= WORDS_IDX))
          err_inc = err_inc + 2'd1;
      end else if (state != DONE) begin
        err_inc = 2'd1;
      end
    end
  end

  // Write stage: word registered on the cycle the FSM enters or stays in WR
  always_ff @(posedge i_user_clk or posedge i_rst) begin
    if (i_rst) begin
      user_valid <= 1'b0;
      user_data  <= '0;
      wr_cnt     <= '0;
      wr_idx     <= '0;
      wait_cnt   <= '0;
    end else begin
      if (state_nxt == WR) begin
        user_valid <= 1'b1;
        user_data  <= wr_cnt;
        wr_cnt     <= wr_cnt + 1'b1;
        wr_idx     <= (state == WR) ? wr_idx + IDX_W'(1) : '0;
      end else begin
        user_valid <= 1'b0;
      end
      wait_cnt <= (state == WAIT) ? wait_cnt + WAIT_W'(1) : '0;
    end
  end

  // Read/check stage: counters registered one cycle after the read word
  always_ff @(posedge i_user_clk or posedge i_rst) begin
    if (i_rst) begin
      exp_cnt     <= '0;
      rd_idx      <= '0;
      o_err_cnt   <= '0;
      o_err       <= 1'b0;
      o_frame_cnt <= '0;
      o_done      <= 1'b0;
    end else begin
      if (state == RD && bus.i_rd_valid) begin
        exp_cnt <= exp_cnt + 1'b1;
        if (rd_idx != WORDS_IDX) rd_idx <= rd_idx + IDX_W'(1);
      end else if (state == NEXT) begin
        rd_idx  <= '0;
        // realign after a short/long frame so one length fault does not cascade
        exp_cnt <= wr_cnt;
      end
      if (err_inc != 2'd0) begin
        o_err_cnt <= sat_add(o_err_cnt, err_inc);
        o_err     <= 1'b1;
      end
      if (state == NEXT) begin
        o_frame_cnt <= o_frame_cnt + 16'd1;
        if (last_frame) o_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi_user_tester.sv
// Directed bench: loopback read model around two tester instances (16-bit and 8-bit data).
module tb_axi_user_tester;

  logic clk;
  logic rst;
  logic init_a;
  logic init_b;

  logic [15:0] frame_a, errc_a, frame_b, errc_b;
  logic        err_a, done_a, err_b, done_b;

  int errors = 0;
  int checks = 0;

  logic [15:0] wmem_a [0:63];
  logic [7:0]  wmem_b [0:511];
  int          wcnt_a;
  int          wcnt_b;
  logic [15:0] errhist [0:15];

  int n, lastd, gap, reqs;

  axi_user_tester_if #(.P_USER_DATA_WIDTH(16), .P_AXI_ADDR_WIDTH(32)) ifa ();
  axi_user_tester_if #(.P_USER_DATA_WIDTH(8),  .P_AXI_ADDR_WIDTH(32)) ifb ();

  axi_user_tester #(
    .P_WR_LENGTH(32), .P_USER_DATA_WIDTH(16), .P_AXI_ADDR_WIDTH(32),
    .P_BASE_ADDR(0), .P_FRAME_NUM(2), .P_WR_WAIT(8)
  ) dut_a (
    .i_user_clk(clk), .i_rst(rst), .i_ddr_init(init_a), .bus(ifa),
    .o_frame_cnt(frame_a), .o_err_cnt(errc_a), .o_err(err_a), .o_done(done_a)
  );

  axi_user_tester #(
    .P_WR_LENGTH(200), .P_USER_DATA_WIDTH(8), .P_AXI_ADDR_WIDTH(32),
    .P_BASE_ADDR(64'h1000), .P_FRAME_NUM(2), .P_WR_WAIT(8)
  ) dut_b (
    .i_user_clk(clk), .i_rst(rst), .i_ddr_init(init_b), .bus(ifb),
    .o_frame_cnt(frame_b), .o_err_cnt(errc_b), .o_err(err_b), .o_done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Loopback memory: records every word the testers write
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt_a <= 0;
    end else if (ifa.o_user_valid && wcnt_a < 64) begin
      wmem_a[wcnt_a] <= ifa.o_user_data;
      wcnt_a <= wcnt_a + 1;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt_b <= 0;
    end else if (ifb.o_user_valid && wcnt_b < 512) begin
      wmem_b[wcnt_b] <= ifb.o_user_data;
      wcnt_b <= wcnt_b + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic write_frame(output int cnt, output int last_word);
    cnt = 0;
    last_word = 0;
    for (int i = 0; i < 40; i++) begin
      if (ifa.o_user_valid !== 1'b1) break;
      cnt++;
      last_word = int'(ifa.o_user_data);
      tick();
    end
  endtask

  task automatic wait_req(output int g);
    g = 1;
    while (ifa.o_user_req !== 1'b1 && g < 60) begin
      tick();
      g++;
    end
  endtask

  task automatic serve_a(input int base, input int corrupt_at, input int last_at);
    for (int i = 0; i < 16; i++) begin
      ifa.i_rd_valid = 1'b1;
      ifa.i_rd_data  = wmem_a[base + i] ^ ((i == corrupt_at) ? 16'h0001 : 16'h0000);
      ifa.i_rd_last  = (i == last_at) || (last_at < 0 && i == 15);
      tick();
      errhist[i] = errc_a;
      if (ifa.i_rd_last) break;
    end
    ifa.i_rd_valid = 1'b0;
    ifa.i_rd_last  = 1'b0;
    ifa.i_rd_data  = '0;
  endtask

  task automatic serve_b(input int base);
    int g;
    g = 0;
    while (ifb.o_user_req !== 1'b1 && g < 1000) begin
      tick();
      g++;
    end
    chk("b_req_timeout", 32'(g < 1000), 1);
    tick();
    for (int i = 0; i < 200; i++) begin
      ifb.i_rd_valid = 1'b1;
      ifb.i_rd_data  = wmem_b[base + i];
      ifb.i_rd_last  = (i == 199);
      tick();
    end
    ifb.i_rd_valid = 1'b0;
    ifb.i_rd_last  = 1'b0;
    ifb.i_rd_data  = '0;
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; init_a = 1'b0; init_b = 1'b0;
    ifa.i_user_busy = 1'b0; ifa.i_rd_valid = 1'b0; ifa.i_rd_last = 1'b0; ifa.i_rd_data = '0;
    ifb.i_user_busy = 1'b0; ifb.i_rd_valid = 1'b0; ifb.i_rd_last = 1'b0; ifb.i_rd_data = '0;
    repeat (3) tick();

    chk("rst_valid", 32'(ifa.o_user_valid), 0);
    chk("rst_data", 32'(ifa.o_user_data), 0);
    chk("rst_req", 32'(ifa.o_user_req), 0);
    chk("rst_frame", 32'(frame_a), 0);
    chk("rst_errcnt", 32'(errc_a), 0);
    chk("rst_done", 32'(done_a), 0);
    chk("a_wbaddr", ifa.o_wuser_baddr, 0);
    chk("a_wfaddr", ifa.o_wuser_faddr, 63);
    chk("a_rfaddr", ifa.o_ruser_faddr, 63);
    chk("b_rbaddr", ifb.o_ruser_baddr, 32'h1000);
    chk("b_wfaddr", ifb.o_wuser_faddr, 32'h118F);
    rst = 1'b0;
    tick(); tick();

    // Run 1: frame 0 with word 5 corrupted, frame 1 with busy held at REQ
    init_a = 1'b1;
    tick(); tick();
    chk("init_lat2", 32'(ifa.o_user_valid), 0);
    tick();
    chk("init_lat3", 32'(ifa.o_user_valid), 1);
    chk("first_word", 32'(ifa.o_user_data), 0);
    write_frame(n, lastd);
    chk("wr_len0", n, 16);
    chk("wr_last0", lastd, 15);
    wait_req(gap);
    chk("req_gap0", gap, 9);
    tick();
    serve_a(0, 5, -1);
    chk("err_before_w5", 32'(errhist[4]), 0);
    chk("err_after_w5", 32'(errhist[5]), 1);
    chk("err_hold", 32'(errhist[15]), 1);
    chk("err_flag", 32'(err_a), 1);
    chk("frame_in_next", 32'(frame_a), 0);
    tick();
    chk("frame_after_next", 32'(frame_a), 1);
    chk("wr_restart", 32'(ifa.o_user_valid), 1);
    chk("wr_first1", 32'(ifa.o_user_data), 16);
    ifa.i_user_busy = 1'b1;
    write_frame(n, lastd);
    chk("wr_len1", n, 16);
    chk("wr_last1", lastd, 31);
    reqs = 0;
    for (int i = 0; i < 28; i++) begin
      if (ifa.o_user_req === 1'b1) reqs++;
      tick();
    end
    chk("busy_noreq", reqs, 0);
    ifa.i_user_busy = 1'b0;
    #1;
    chk("req_pulse", 32'(ifa.o_user_req), 1);
    tick();
    chk("req_once", 32'(ifa.o_user_req), 0);
    serve_a(16, -1, -1);
    tick();
    chk("run1_frames", 32'(frame_a), 2);
    chk("run1_errcnt", 32'(errc_a), 1);
    chk("run1_done", 32'(done_a), 1);
    chk("run1_wcnt", wcnt_a, 32);
    chk("run1_mem16", 32'(wmem_a[16]), 16);
    repeat (5) tick();
    chk("done_hold_valid", 32'(ifa.o_user_valid), 0);
    chk("done_hold_frames", 32'(frame_a), 2);

    // Run 2: reset mid-frame, then a clean two-frame run
    rst = 1'b1;
    #1;
    chk("rst2_done", 32'(done_a), 0);
    chk("rst2_err", 32'(err_a), 0);
    chk("rst2_frames", 32'(frame_a), 0);
    init_a = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    init_a = 1'b1;
    repeat (3) tick();
    repeat (7) tick();
    chk("word7", 32'(ifa.o_user_data), 7);
    rst = 1'b1;
    #1;
    chk("abort_valid", 32'(ifa.o_user_valid), 0);
    chk("abort_data", 32'(ifa.o_user_data), 0);
    tick();
    rst = 1'b0;
    init_a = 1'b0;
    tick();
    init_a = 1'b1;
    repeat (3) tick();
    chk("restart_valid", 32'(ifa.o_user_valid), 1);
    chk("restart_word", 32'(ifa.o_user_data), 0);
    write_frame(n, lastd);
    wait_req(gap);
    tick();
    serve_a(0, -1, -1);
    tick();
    write_frame(n, lastd);
    wait_req(gap);
    tick();
    serve_a(16, -1, -1);
    tick();
    chk("run2_frames", 32'(frame_a), 2);
    chk("run2_errcnt", 32'(errc_a), 0);
    chk("run2_err", 32'(err_a), 0);
    chk("run2_done", 32'(done_a), 1);
    chk("run2_mem31", 32'(wmem_a[31]), 31);

    // Run 3: stray valid in IDLE, then last on word 10 together with a mismatch
    rst = 1'b1;
    init_a = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    ifa.i_rd_valid = 1'b1;
    ifa.i_rd_data  = 16'h00AA;
    tick();
    ifa.i_rd_valid = 1'b0;
    ifa.i_rd_data  = '0;
    chk("stray_errcnt", 32'(errc_a), 1);
    init_a = 1'b1;
    repeat (3) tick();
    write_frame(n, lastd);
    wait_req(gap);
    tick();
    serve_a(0, 10, 10);
    chk("len_before", 32'(errhist[9]), 1);
    chk("len_plus_mismatch", 32'(errhist[10]), 3);
    chk("len_next_frame", 32'(frame_a), 0);
    tick();
    chk("len_frame_adv", 32'(frame_a), 1);
    chk("len_wr_first", 32'(ifa.o_user_data), 16);

    // Run B: 8-bit data, counter wraps inside frame 1
    rst = 1'b1;
    init_a = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    init_b = 1'b1;
    serve_b(0);
    serve_b(200);
    tick();
    chk("b_wcnt", wcnt_b, 400);
    chk("b_mem200", 32'(wmem_b[200]), 200);
    chk("b_mem255", 32'(wmem_b[255]), 255);
    chk("b_mem256", 32'(wmem_b[256]), 0);
    chk("b_mem399", 32'(wmem_b[399]), 143);
    chk("b_errcnt", 32'(errc_b), 0);
    chk("b_frames", 32'(frame_b), 2);
    chk("b_done", 32'(done_b), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
